mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8: byte-address width of the storage, giving 2**ADDR_BITS bytes (256).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 Address  input  32  byte address of the request.
REQ-005 WriteData  input  32  store data; the low bytes are used for half and byte stores.
REQ-006 MemWr  input  1  write request strobe, one cycle.
REQ-007 MemRd  input  1  read request strobe, one cycle.
REQ-008 Size  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-009 ReadData  output  32  read result, zero-extended for half and byte reads.
REQ-010 DataValid  output  1  ReadData is valid this cycle (one-cycle pulse).
REQ-011 Busy  output  1  a read is in flight; new requests are not accepted.
REQ-012 AddrError  output  1  one-cycle pulse: the request was rejected (misaligned, out of range, or reserved Size).
REQ-013 ReqDropped  output  1  one-cycle pulse: a request was ignored because of Busy or a read/write collision.

Function
REQ-014 The FSM SHALL have states IDLE, RD1 and RD2; writes complete in IDLE without leaving it.
REQ-015 In IDLE with MemRd=1, MemWr=0 and a legal request, the block SHALL latch Address and Size and go IDLE->RD1->RD2->IDLE, one state per edge.
REQ-016 In RD2, ReadData SHALL be driven from storage and DataValid SHALL be 1, i.e. the second cycle after the request cycle (fixed latency 2).
REQ-017 ReadData SHALL hold its last value after RD2 until the next RD2 or a reset.
REQ-018 Busy SHALL be 1 exactly in RD1 and RD2.
REQ-019 In IDLE with MemWr=1 and a legal request, storage SHALL be updated at that edge; the write affects no other output.
REQ-020 Byte order SHALL be little-endian: a word at A occupies bytes A..A+3, with byte A in bits [7:0].
REQ-021 A write of size half or byte SHALL update only the addressed bytes.
REQ-022 A request SHALL be legal only if all of the following hold:
  - Size != 11;
  - Address[31:ADDR_BITS] == 0;
  - word requests have Address[1:0] == 00;
  - half requests have Address[0] == 0.
REQ-023 An illegal request accepted in IDLE SHALL pulse AddrError on the next cycle, with no storage change and no state change.
REQ-024 MemWr=1 and MemRd=1 together in IDLE: the write SHALL proceed (if legal), the read SHALL be discarded, and ReqDropped SHALL pulse on the next cycle.
REQ-025 Any MemRd or MemWr while Busy=1 SHALL be ignored (no storage change) and SHALL pulse ReqDropped on the next cycle.
REQ-026 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-027 AddrError and ReqDropped SHALL never be asserted in the same cycle; ReqDropped takes precedence.

Reset
REQ-028 With reset=0 at an edge, the block SHALL enter IDLE and set ReadData=0, DataValid=0, Busy=0, AddrError=0 and ReqDropped=0.
REQ-029 Reset SHALL NOT clear storage contents.
REQ-030 A reset during RD1 or RD2 SHALL abort the read; no DataValid pulse follows.
REQ-031 Requests presented while reset=0 SHALL be ignored.

Verification
REQ-032 Word store 0xDEADBEEF at 0x10, then word read 0x10 -> DataValid exactly 2 cycles after MemRd, ReadData=0xDEADBEEF, Busy high for 2 cycles.
REQ-033 Byte store 0xAB at 0x11, then word read 0x10 -> 0xDEADABEF; byte read 0x13 -> 0x000000DE; half read 0x12 -> 0x0000DEAD.
REQ-034 Word read at 0x12, half read at 0x11, word read at 0x100, and Size=11 each -> AddrError pulse, no DataValid, Busy stays 0, storage unchanged.
REQ-035 MemRd at 0x10 followed by MemWr 0x0 at 0x10 during RD1 -> write ignored, ReqDropped pulse, ReadData=0xDEADABEF.
REQ-036 MemRd and MemWr together at 0x20 with data 0x12345678 -> ReqDropped pulse, no DataValid; a later read of 0x20 returns 0x12345678.
REQ-037 Reset asserted in RD1 -> no DataValid and all outputs 0; after release, a read of 0x10 still returns 0xDEADABEF.

Source files
------------

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between a requester and mem_responder
interface mem_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWr;
  logic        MemRd;
  logic [1:0]  Size;
  logic [31:0] ReadData;
  logic        DataValid;
  logic        Busy;
  logic        AddrError;
  logic        ReqDropped;

  modport master (
    output Address, WriteData, MemWr, MemRd, Size,
    input  ReadData, DataValid, Busy, AddrError, ReqDropped
  );

  modport slave (
    input  Address, WriteData, MemWr, MemRd, Size,
    output ReadData, DataValid, Busy, AddrError, ReqDropped
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-addressed little-endian memory with fixed two-cycle read latency
// Writes complete in IDLE; reads walk IDLE->RD1->RD2 and present data in RD2.
module mem_responder #(
  parameter int ADDR_BITS = 8
) (
  input logic            clock,
  input logic            reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;

  state_t               state;
  logic [7:0]           mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] rd_addr;
  logic [1:0]           rd_size;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 legal;
  logic                 wr_en;
  logic [31:0]          rd_word;

  assign req_addr = bus.Address[ADDR_BITS-1:0];

  always_comb begin
    legal = 1'b1;
    if (bus.Size == 2'b11)
      legal = 1'b0;
    if ((bus.Address >> ADDR_BITS) != 32'd0)
      legal = 1'b0;
    if (bus.Size == 2'b00 && bus.Address[1:0] != 2'b00)
      legal = 1'b0;
    if (bus.Size == 2'b01 && bus.Address[0] != 1'b0)
      legal = 1'b0;
  end

  // A simultaneous read turns the cycle into a collision, but the write still lands.
  assign wr_en = reset && (state == IDLE) && bus.MemWr && legal;

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      case (bus.Size)
        2'b00: begin
          mem[{req_addr[ADDR_BITS-1:2], 2'b00}] <= bus.WriteData[7:0];
          mem[{req_addr[ADDR_BITS-1:2], 2'b01}] <= bus.WriteData[15:8];
          mem[{req_addr[ADDR_BITS-1:2], 2'b10}] <= bus.WriteData[23:16];
          mem[{req_addr[ADDR_BITS-1:2], 2'b11}] <= bus.WriteData[31:24];
        end
        2'b01: begin
          mem[{req_addr[ADDR_BITS-1:1], 1'b0}] <= bus.WriteData[7:0];
          mem[{req_addr[ADDR_BITS-1:1], 1'b1}] <= bus.WriteData[15:8];
        end
        2'b10: mem[req_addr] <= bus.WriteData[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = 32'd0;
    case (rd_size)
      2'b00: rd_word = {mem[{rd_addr[ADDR_BITS-1:2], 2'b11}],
                        mem[{rd_addr[ADDR_BITS-1:2], 2'b10}],
                        mem[{rd_addr[ADDR_BITS-1:2], 2'b01}],
                        mem[{rd_addr[ADDR_BITS-1:2], 2'b00}]};
      2'b01: rd_word = {16'h0000,
                        mem[{rd_addr[ADDR_BITS-1:1], 1'b1}],
                        mem[{rd_addr[ADDR_BITS-1:1], 1'b0}]};
      default: rd_word = {24'h000000, mem[rd_addr]};
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      rd_addr        <= '0;
      rd_size        <= 2'b00;
      bus.ReadData   <= 32'd0;
      bus.DataValid  <= 1'b0;
      bus.Busy       <= 1'b0;
      bus.AddrError  <= 1'b0;
      bus.ReqDropped <= 1'b0;
    end else begin
      bus.DataValid  <= 1'b0;
      bus.AddrError  <= 1'b0;
      bus.ReqDropped <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.MemRd && bus.MemWr) begin
            bus.ReqDropped <= 1'b1;
          end else if ((bus.MemRd || bus.MemWr) && !legal) begin
            bus.AddrError <= 1'b1;
          end else if (bus.MemRd) begin
            rd_addr  <= req_addr;
            rd_size  <= bus.Size;
            state    <= RD1;
            bus.Busy <= 1'b1;
          end
        end
        RD1: begin
          state          <= RD2;
          bus.ReadData   <= rd_word;
          bus.DataValid  <= 1'b1;
          bus.ReqDropped <= bus.MemRd || bus.MemWr;
        end
        RD2: begin
          state          <= IDLE;
          bus.Busy       <= 1'b0;
          bus.ReqDropped <= bus.MemRd || bus.MemWr;
        end
        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder
module tb_mem_responder;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  mem_responder_if bus ();

  mem_responder #(.ADDR_BITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_req();
    bus.MemRd     = 1'b0;
    bus.MemWr     = 1'b0;
    bus.Address   = 32'd0;
    bus.WriteData = 32'd0;
    bus.Size      = 2'b00;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size);
    bus.MemRd     = rd;
    bus.MemWr     = wr;
    bus.Address   = addr;
    bus.WriteData = data;
    bus.Size      = size;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".rdata"}, bus.ReadData, 32'd0);
    check({tag, ".valid"}, {31'd0, bus.DataValid}, 32'd0);
    check({tag, ".busy"}, {31'd0, bus.Busy}, 32'd0);
    check({tag, ".aerr"}, {31'd0, bus.AddrError}, 32'd0);
    check({tag, ".drop"}, {31'd0, bus.ReqDropped}, 32'd0);
  endtask

  // All tasks start and end on a falling edge so the next request lands one cycle later.
  task automatic do_write(input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] size);
    drive(1'b0, 1'b1, addr, data, size);
    @(negedge clock);
    clear_req();
    check({tag, ".aerr"}, {31'd0, bus.AddrError}, 32'd0);
    check({tag, ".drop"}, {31'd0, bus.ReqDropped}, 32'd0);
    check({tag, ".busy"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] exp);
    drive(1'b1, 1'b0, addr, 32'd0, size);
    @(negedge clock);
    clear_req();
    check({tag, ".busy1"}, {31'd0, bus.Busy}, 32'd1);
    check({tag, ".valid1"}, {31'd0, bus.DataValid}, 32'd0);
    @(negedge clock);
    check({tag, ".busy2"}, {31'd0, bus.Busy}, 32'd1);
    check({tag, ".valid2"}, {31'd0, bus.DataValid}, 32'd1);
    check({tag, ".data"}, bus.ReadData, exp);
    @(negedge clock);
    check({tag, ".busy3"}, {31'd0, bus.Busy}, 32'd0);
    check({tag, ".valid3"}, {31'd0, bus.DataValid}, 32'd0);
    check({tag, ".hold"}, bus.ReadData, exp);
  endtask

  task automatic do_bad(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size);
    drive(~wr, wr, addr, 32'hFFFF_FFFF, size);
    @(negedge clock);
    clear_req();
    check({tag, ".aerr"}, {31'd0, bus.AddrError}, 32'd1);
    check({tag, ".drop"}, {31'd0, bus.ReqDropped}, 32'd0);
    check({tag, ".busy"}, {31'd0, bus.Busy}, 32'd0);
    @(negedge clock);
    check({tag, ".aerr_end"}, {31'd0, bus.AddrError}, 32'd0);
    check({tag, ".valid"}, {31'd0, bus.DataValid}, 32'd0);
    check({tag, ".busy_end"}, {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    clear_req();
    repeat (3) @(negedge clock);
    check_quiet("rst");
    reset = 1'b1;
    @(negedge clock);

    do_write("wr_word", 32'h10, 32'hDEAD_BEEF, 2'b00);
    do_read("rd_word", 32'h10, 2'b00, 32'hDEAD_BEEF);

    do_write("wr_byte", 32'h11, 32'h0000_00AB, 2'b10);
    do_read("rd_after_byte", 32'h10, 2'b00, 32'hDEAD_ABEF);
    do_read("rd_byte13", 32'h13, 2'b10, 32'h0000_00DE);
    do_read("rd_half12", 32'h12, 2'b01, 32'h0000_DEAD);

    do_write("wr_zero", 32'h00, 32'h1122_3344, 2'b00);
    do_bad("bad_rd_word12", 1'b0, 32'h12, 2'b00);
    do_bad("bad_rd_half11", 1'b0, 32'h11, 2'b01);
    do_bad("bad_rd_range", 1'b0, 32'h100, 2'b00);
    do_bad("bad_rd_size3", 1'b0, 32'h10, 2'b11);
    do_bad("bad_wr_word12", 1'b1, 32'h12, 2'b00);
    do_bad("bad_wr_size3", 1'b1, 32'h10, 2'b11);
    do_bad("bad_wr_range", 1'b1, 32'h100, 2'b00);
    do_read("rd_unchanged10", 32'h10, 2'b00, 32'hDEAD_ABEF);
    do_read("rd_unchanged00", 32'h00, 2'b00, 32'h1122_3344);

    // write arriving while the read is in RD1
    drive(1'b1, 1'b0, 32'h10, 32'd0, 2'b00);
    @(negedge clock);
    drive(1'b0, 1'b1, 32'h10, 32'h0000_0000, 2'b00);
    check("busy_wr.busy", {31'd0, bus.Busy}, 32'd1);
    @(negedge clock);
    clear_req();
    check("busy_wr.drop", {31'd0, bus.ReqDropped}, 32'd1);
    check("busy_wr.valid", {31'd0, bus.DataValid}, 32'd1);
    check("busy_wr.data", bus.ReadData, 32'hDEAD_ABEF);
    @(negedge clock);
    check("busy_wr.drop_end", {31'd0, bus.ReqDropped}, 32'd0);
    check("busy_wr.busy_end", {31'd0, bus.Busy}, 32'd0);
    do_read("rd_after_busy_wr", 32'h10, 2'b00, 32'hDEAD_ABEF);

    drive(1'b1, 1'b1, 32'h20, 32'h1234_5678, 2'b00);
    @(negedge clock);
    clear_req();
    check("coll.drop", {31'd0, bus.ReqDropped}, 32'd1);
    check("coll.aerr", {31'd0, bus.AddrError}, 32'd0);
    check("coll.busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge clock);
    check("coll.valid", {31'd0, bus.DataValid}, 32'd0);
    check("coll.drop_end", {31'd0, bus.ReqDropped}, 32'd0);
    do_read("rd_coll", 32'h20, 2'b00, 32'h1234_5678);

    // illegal collision: ReqDropped wins over AddrError
    drive(1'b1, 1'b1, 32'h22, 32'hFFFF_FFFF, 2'b00);
    @(negedge clock);
    clear_req();
    check("coll_bad.drop", {31'd0, bus.ReqDropped}, 32'd1);
    check("coll_bad.aerr", {31'd0, bus.AddrError}, 32'd0);
    @(negedge clock);
    do_read("rd_coll_bad", 32'h20, 2'b00, 32'h1234_5678);

    // reset in RD1, with a write presented during reset
    drive(1'b1, 1'b0, 32'h10, 32'd0, 2'b00);
    @(negedge clock);
    check("rst_rd1.busy", {31'd0, bus.Busy}, 32'd1);
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h10, 32'h0000_0000, 2'b00);
    @(negedge clock);
    check_quiet("rst_rd1.a");
    @(negedge clock);
    check_quiet("rst_rd1.b");
    clear_req();
    reset = 1'b1;
    @(negedge clock);
    check_quiet("rst_rel");
    do_read("rd_after_rst", 32'h10, 2'b00, 32'hDEAD_ABEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
